// File: rtl/ahb_spi_slave_if_if.sv
// ahb_spi_slave_if_if: AHB-Lite slave bus plus SPI engine command/response signals
// bundled for the AHB-to-SPI bridge front end.
interface ahb_spi_slave_if_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              HSEL;
   logic [ADDR_W-1:0] HADDR;
   logic [1:0]        HTRANS;
   logic              HWRITE;
   logic [2:0]        HSIZE;
   logic [2:0]        HBURST;
   logic [DATA_W-1:0] HWDATA;
   logic [DATA_W-1:0] HRDATA;
   logic              HREADY;
   logic              HRESP;
   logic              spi_start;
   logic              spi_write;
   logic [ADDR_W-1:0] spi_addr;
   logic [2:0]        spi_size;
   logic [DATA_W-1:0] spi_wdata;
   logic              spi_abort;
   logic              spi_done;
   logic [DATA_W-1:0] spi_rdata;
   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, spi_done, spi_rdata,
      output HRDATA, HREADY, HRESP, spi_start, spi_write, spi_addr, spi_size, spi_wdata, spi_abort
   );
   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, spi_done, spi_rdata,
      input  HRDATA, HREADY, HRESP, spi_start, spi_write, spi_addr, spi_size, spi_wdata, spi_abort
   );
endinterface

// File: rtl/ahb_spi_slave_if.sv
// ahb_spi_slave_if: AHB-Lite slave front end that turns each accepted beat into one SPI
// command and stretches the data phase with wait states until the SPI engine answers.
module ahb_spi_slave_if #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255,
   parameter int TW      = 8
) (
   input logic HCLK,
   input logic rst,
   ahb_spi_slave_if_if.slave bus
);
   typedef enum logic [2:0] {IDLE, START, WAIT, RESP, ERR1, ERR2} state_e;
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;
   logic [2:0]        size_q;
   logic              write_q, abort_q;
   logic [TW-1:0]     timer_q;
   logic              valid, illegal, timeout;
   assign valid   = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
   assign illegal = (bus.HSIZE > 3'd2) | (bus.HSIZE == 3'd1 & bus.HADDR[0]) |
                    (bus.HSIZE == 3'd2 & |bus.HADDR[1:0]);
   assign timeout = timer_q == TW'(TIMEOUT - 1);
   always_ff @(posedge HCLK) state_q <= rst ? IDLE : state_d;
   // IDLE, RESP and ERR2 all hold HREADY high, so each samples the next address phase
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, RESP, ERR2: state_d = valid ? (illegal ? ERR1 : START) : IDLE;
         START:            state_d = WAIT;
         WAIT:             state_d = bus.spi_done ? RESP : (timeout ? ERR1 : WAIT);
         ERR1:             state_d = ERR2;
         default:          state_d = IDLE;
      endcase
   end
   // write data is forwarded straight from the data phase during START so the engine sees it with the pulse
   always_comb begin
      bus.HREADY    = state_q inside {IDLE, RESP, ERR2};
      bus.HRESP     = state_q inside {ERR1, ERR2};
      bus.HRDATA    = rdata_q;
      bus.spi_start = state_q == START;
      bus.spi_write = write_q;
      bus.spi_addr  = addr_q;
      bus.spi_size  = size_q;
      bus.spi_wdata = (state_q == START && write_q) ? bus.HWDATA : wdata_q;
      bus.spi_abort = abort_q;
   end
   always_ff @(posedge HCLK) begin
      if (rst) begin
         addr_q  <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         timer_q <= '0;
         abort_q <= 1'b0;
      end else begin
         if (valid && !illegal) begin
            addr_q  <= bus.HADDR;
            size_q  <= bus.HSIZE;
            write_q <= bus.HWRITE;
         end
         if (state_q == START && write_q) wdata_q <= bus.HWDATA;
         if (state_q == WAIT && bus.spi_done && !write_q) rdata_q <= bus.spi_rdata;
         timer_q <= (state_q == WAIT) ? timer_q + 1'b1 : '0;
         // a done arriving on the last allowed cycle beats the timeout
         abort_q <= state_q == WAIT && !bus.spi_done && timeout;
      end
   end
endmodule

// File: doc/ahb_spi_slave_if.md
Name: ahb_spi_slave_if

Overview:
- AHB-Lite slave front end of the AHB-to-SPI bridge; consumes the address/control/data phases driven by the AHB master.
- Converts each accepted beat into a single-transaction command for the SPI master engine (spi_start/spi_done handshake).
- Returns HRDATA/HREADY/HRESP to the master, inserting wait states while the SPI transaction is in flight.
- Flags illegal transfers and SPI timeouts with a two-cycle ERROR response.

Parameters:
- ADDR_W, 8: HADDR / spi_addr width.
- DATA_W, 32: HWDATA / HRDATA / SPI data width.
- TIMEOUT, 255: max WAIT cycles before the slave gives up.
- TW, 8: timeout counter width; must satisfy TIMEOUT < 2^TW.

Ports:
- HCLK  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select; tied high in a single-slave system.
- HADDR  in  ADDR_W  address-phase address.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  000 byte, 001 half, 010 word; others illegal.
- HBURST  in  3  accepted but not decoded; every beat is handled independently.
- HWDATA  in  DATA_W  write data, valid in the data phase.
- HRDATA  out  DATA_W  read data.
- HREADY  out  1  transfer-done / address-sample qualifier; also fed back internally.
- HRESP  out  1  0 OKAY, 1 ERROR.
- spi_start  out  1  one-cycle command pulse.
- spi_write  out  1  latched HWRITE.
- spi_addr  out  ADDR_W  latched HADDR.
- spi_size  out  3  latched HSIZE.
- spi_wdata  out  DATA_W  latched HWDATA.
- spi_abort  out  1  one-cycle pulse on timeout.
- spi_done  in  1  SPI transaction complete; single-cycle pulse.
- spi_rdata  in  DATA_W  read result, valid with spi_done.

Behaviour:
- Valid transfer = HSEL & HTRANS[1] & HREADY.
  - IDLE and BUSY get an OKAY response with no SPI activity.
- Illegal transfer, flagged when the address phase is sampled:
  - HSIZE > 2, or
  - HSIZE = 1 with HADDR[0] = 1, or
  - HSIZE = 2 with HADDR[1:0] != 0.
- Reset values: HREADY = 1, HRESP = 0, HRDATA = 0, all spi_* outputs = 0, timer = 0, state = IDLE.
- States:
  - IDLE: HREADY = 1, HRESP = 0.
    - Valid and legal: latch addr/write/size -> START.
    - Valid and illegal: -> ERR1.
    - Otherwise stay in IDLE.
  - START: HREADY = 0, spi_start = 1 for this single cycle.
    - spi_wdata <= HWDATA (data phase of the write); for reads spi_wdata is held.
    - Timer cleared. -> WAIT.
  - WAIT: HREADY = 0; timer increments each cycle.
    - On spi_done: if read, HRDATA <= spi_rdata; -> RESP.
    - Else if timer == TIMEOUT-1: spi_abort pulse -> ERR1.
  - RESP: HREADY = 1, HRESP = 0. The next address phase is sampled here (pipelined) using the same decode as IDLE: -> START, ERR1 or IDLE.
  - ERR1: HREADY = 0, HRESP = 1. -> ERR2.
  - ERR2: HREADY = 1, HRESP = 1. Samples the next address phase exactly like RESP.
- Latency: address phase T0, START T1, earliest spi_done T2, RESP T3. Minimum 2 wait states per beat.
- HRDATA holds its last value until the next successful read completes; it is not cleared on writes or errors.
- spi_addr, spi_write and spi_size are stable from START until the next START.
- spi_done seen outside WAIT is ignored.
- spi_done in the same cycle as timer == TIMEOUT-1: done wins, so OKAY is returned and no abort is issued.
- SEQ beats are treated like NONSEQ: each beat issues its own spi_start.
- rst asserted in any state: next edge returns to IDLE with reset values. An in-flight SPI command is abandoned and no spi_abort is issued.
- HREADY must never be low while state is IDLE.

Test Plan:
- Reset, then a word write to 0x10 with HWDATA = 0xDEADBEEF, spi_done 3 cycles after spi_start:
  - expect spi_start in T1 with spi_addr = 0x10, spi_write = 1, spi_size = 2, spi_wdata = 0xDEADBEEF;
  - expect HREADY low until the cycle after spi_done, then HRESP = 0.
- Word read from 0x24 with spi_rdata = 0x12345678 on spi_done:
  - expect HRDATA = 0x12345678 in the RESP cycle with HREADY = 1 and HRESP = 0.
- Back-to-back NONSEQ write to 0x00 then read from 0x04, second address presented during the first RESP:
  - expect the second spi_start on the cycle immediately after RESP, with no IDLE cycle in between.
- Illegal transfer: HSIZE = 2 at HADDR = 0x02, and separately HSIZE = 3 at 0x00:
  - expect no spi_start;
  - expect ERR1 (HREADY = 0, HRESP = 1) then ERR2 (HREADY = 1, HRESP = 1), then IDLE if HTRANS = IDLE.
- Timeout: read issued, spi_done never arrives:
  - expect spi_abort pulsed exactly TIMEOUT cycles after entering WAIT, followed by the two-cycle ERROR response;
  - expect a late spi_done to be ignored.
- rst asserted mid-WAIT, then a new write to 0x08:
  - expect HREADY = 1, HRESP = 0 and spi_* = 0 on the next edge;
  - expect the new transfer to complete normally.
